// File: rtl/cpu_flags_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_flags_pkg
// Brief    : Shared flag bit positions, default sizes and stack-op decode
//            for the CPU status-flag register file.
// Revision : 1.0  initial release
// ============================================================================
package cpu_flags_pkg;

  localparam int FLAG_Z         = 0;
  localparam int FLAG_S         = 1;
  localparam int FLAG_C         = 2;
  localparam int FLAG_V         = 3;
  localparam int NFLAGS_DEFAULT = 4;

  // Stack request seen in one cycle; push and pop together cancel out.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    stack_op_e op;
    op = OP_NONE;
    if (push && pop)      op = OP_BOTH;
    else if (push)        op = OP_PUSH;
    else if (pop)         op = OP_POP;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_status_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : flag_status_regs_if
// Brief    : Control/status bundle between ALU/interrupt controller and the
//            status-flag register file.
// Revision : 1.0  initial release
// ============================================================================
interface flag_status_regs_if #(
  parameter int NFLAGS      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
);
  logic              we;
  logic [NFLAGS-1:0] wmask;
  logic [NFLAGS-1:0] flags_in;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [NFLAGS-1:0] flags_out;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output we, wmask, flags_in, push, pop, err_clr,
    input  flags_out, count, full, empty, ovf_err, unf_err
  );

  modport slave (
    input  we, wmask, flags_in, push, pop, err_clr,
    output flags_out, count, full, empty, ovf_err, unf_err
  );
endinterface
`default_nettype wire

// File: rtl/flag_status_regs_dffe_n.sv
`default_nettype none
// ============================================================================
// Module   : dffe_n
// Brief    : Enabled register bank with asynchronous active-low clear.
// Revision : 1.0  initial release
// ============================================================================
module dffe_n #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] d,
  input  wire logic             clk,
  input  wire logic             clrn,
  input  wire logic             e,
  output logic      [WIDTH-1:0] q
);

  // Load d when enabled; clear immediately whenever clrn is low.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)  q <= '0;
    else if (e) q <= d;
  end

endmodule
`default_nettype wire

// File: rtl/flag_status_regs.sv
`default_nettype none
// ============================================================================
// Module   : flag_status_regs
// Brief    : Live CPU status flags with per-flag masked write and a LIFO
//            save/restore stack for interrupt entry/return, with sticky
//            overflow/underflow error bits.
// Revision : 1.0  initial release
// ============================================================================
module flag_status_regs
  import cpu_flags_pkg::*;
#(
  parameter int NFLAGS      = NFLAGS_DEFAULT,
  parameter int STACK_DEPTH = 4
) (
  input wire logic          clk,
  input wire logic          clrn,
  flag_status_regs_if.slave bus
);

  localparam int              CNT_W   = $clog2(STACK_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

  logic [NFLAGS-1:0] live_q;
  logic [NFLAGS-1:0] live_d;
  logic              live_en;
  logic [NFLAGS-1:0] stack_q [STACK_DEPTH];
  logic [NFLAGS-1:0] top_entry;
  logic [CNT_W-1:0]  count_q;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;
  logic              ovf_ev;
  logic              unf_ev;
  logic              ovf_q;
  logic              unf_q;
  stack_op_e         op;

  assign op      = decode_op(bus.push, bus.pop);
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = (op == OP_PUSH) && !full;
  assign do_pop  = (op == OP_POP)  && !empty;
  assign ovf_ev  = (op == OP_PUSH) &&  full;
  assign unf_ev  = (op == OP_POP)  &&  empty;

  // Select the most recently saved entry (index count-1); zero when empty.
  always_comb begin
    top_entry = '0;
    for (int j = 0; j < STACK_DEPTH; j++) begin
      if (count_q == CNT_W'(j + 1)) top_entry = stack_q[j];
    end
  end

  // A successful pop restores flags and discards any same-cycle ALU write.
  assign live_d  = do_pop ? top_entry
                          : ((live_q & ~bus.wmask) | (bus.flags_in & bus.wmask));
  assign live_en = do_pop | bus.we;

  dffe_n #(.WIDTH(NFLAGS)) u_live (
    .d    (live_d),
    .clk  (clk),
    .clrn (clrn),
    .e    (live_en),
    .q    (live_q)
  );

  // Stack entries capture the pre-write live flags at the slot indexed by count.
  generate
    for (genvar j = 0; j < STACK_DEPTH; j++) begin : g_stack
      logic entry_en;
      assign entry_en = do_push && (count_q == CNT_W'(j));
      dffe_n #(.WIDTH(NFLAGS)) u_entry (
        .d    (live_q),
        .clk  (clk),
        .clrn (clrn),
        .e    (entry_en),
        .q    (stack_q[j])
      );
    end
  endgenerate

  // Occupancy count; only effective pushes/pops move it, so it saturates.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)        count_q <= '0;
    else if (do_push) count_q <= count_q + CNT_W'(1);
    else if (do_pop)  count_q <= count_q - CNT_W'(1);
  end

  // Sticky error bits; a new error event overrides a same-cycle clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_ev | (ovf_q & ~bus.err_clr);
      unf_q <= unf_ev | (unf_q & ~bus.err_clr);
    end
  end

  assign bus.flags_out = live_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_status_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_status_regs
// Brief    : Scoreboard bench for flag_status_regs: directed scenarios plus
//            random traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_flag_status_regs;
  import cpu_flags_pkg::*;

  localparam int NF = 4;
  localparam int SD = 4;
  localparam int CW = $clog2(SD + 1);

  typedef struct packed {
    logic [NF-1:0] flags;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } obs_t;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  flag_status_regs_if #(.NFLAGS(NF), .STACK_DEPTH(SD)) bus ();

  flag_status_regs #(.NFLAGS(NF), .STACK_DEPTH(SD)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  // Reference model: live flags, a queue used as a LIFO, sticky errors.
  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_stack[$];
  logic          m_ovf;
  logic          m_unf;

  function void model_reset();
    m_flags = '0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function obs_t model_obs();
    obs_t o;
    o.flags = m_flags;
    o.count = CW'(m_stack.size());
    o.full  = (m_stack.size() == SD);
    o.empty = (m_stack.size() == 0);
    o.ovf   = m_ovf;
    o.unf   = m_unf;
    return o;
  endfunction

  function obs_t sample();
    obs_t o;
    o.flags = bus.flags_out;
    o.count = bus.count;
    o.full  = bus.full;
    o.empty = bus.empty;
    o.ovf   = bus.ovf_err;
    o.unf   = bus.unf_err;
    return o;
  endfunction

  task automatic check_now(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b, expected flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
               name, got.flags, got.count, got.full, got.empty, got.ovf, got.unf,
               exp.flags, exp.count, exp.full, exp.empty, exp.ovf, exp.unf);
    end
  endtask

  task automatic set_idle();
    bus.we = 1'b0; bus.wmask = '0; bus.flags_in = '0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue the model's expected outcome.
  task automatic step(input logic we, input logic [NF-1:0] wmask, input logic [NF-1:0] fin,
                      input logic push, input logic pop, input logic clr);
    logic [NF-1:0] nf;
    logic          ev_ovf, ev_unf;
    @(negedge clk);
    bus.we = we; bus.wmask = wmask; bus.flags_in = fin;
    bus.push = push; bus.pop = pop; bus.err_clr = clr;
    nf = m_flags;
    ev_ovf = 1'b0;
    ev_unf = 1'b0;
    if (we) nf = (m_flags & ~wmask) | (fin & wmask);
    if (push && !pop) begin
      if (m_stack.size() == SD) ev_ovf = 1'b1;
      else m_stack.push_back(m_flags);
    end
    if (pop && !push) begin
      if (m_stack.size() == 0) ev_unf = 1'b1;
      else nf = m_stack.pop_back();
    end
    m_flags = nf;
    m_ovf = ev_ovf | (m_ovf & ~clr);
    m_unf = ev_unf | (m_unf & ~clr);
    exp_q.push_back(model_obs());
  endtask

  // Return inputs to idle and wait (bounded) for the monitor to consume everything.
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    set_idle();
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: outputs are valid every cycle; compare one queued expectation per edge.
  always @(posedge clk) begin
    obs_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_now("cycle", sample(), e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0;
    set_idle();
    model_reset();
    #1;
    check_now("power_on_reset", sample(), model_obs());
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    // Masked write: only Z and C positions take the new value.
    step(1'b1, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0);

    // Save/restore with a concurrent write on the push cycle.
    step(1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Overflow, clear, and an error event winning over a same-cycle clear.
    for (int i = 0; i < SD + 1; i++)
      step(1'b1, 4'b1111, NF'(i + 3), 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < SD; i++)
      step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Underflow keeps the write; then pop discards a concurrent write.
    step(1'b1, 4'b1111, 4'b0110, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'b1111, 4'b1001, 1'b0, 1'b1, 1'b0);

    // push and pop together at count 2: no stack op, write applies.
    step(1'b1, 4'b1111, 4'b1100, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 4'b1111, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-operation (count is 2 here).
    @(negedge clk);
    #2;
    clrn = 1'b0;
    model_reset();
    #1;
    check_now("async_reset", sample(), model_obs());
    @(posedge clk);
    #1;
    check_now("reset_held", sample(), model_obs());
    @(negedge clk);
    clrn = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), NF'($urandom), NF'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
